lag_packet_port_scheduler: RTL
==============================

# lag_packet_port_scheduler

Packet-level scheduler that shares one router output port among SIZE input virtual channels. It grants the port with a two-level round-robin: round-robin within each group of GROUPSIZE requesters, and round-robin among groups. A grant is held for the whole packet, from head flit to tail flit. The block also tracks downstream buffer credits. It sits between the input VC buffers and the output crossbar column it drives.

## Interface
- SIZE, 20, number of requesting input VCs
- GROUPSIZE, 4, requesters per group; SIZE must be an exact multiple
- NUMGROUPS, SIZE/GROUPSIZE, number of groups (derived; do not override)
- CREDITS, 4, downstream buffer depth in flits; must be at least 1
- CW, $clog2(CREDITS+1), credit counter width (derived)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  SIZE  requester i has a flit ready
- tail  in  SIZE  flit currently offered by requester i is a tail flit; a head+tail single-flit packet sets it
- credit_in  in  1  one-cycle pulse; returns one downstream credit
- grant  out  SIZE  one-hot or zero; a flit transfers from requester i this cycle
- grant_valid  out  1  OR of grant
- grant_idx  out  $clog2(SIZE)  index of the granted requester; 0 when grant_valid=0
- locked  out  1  a multi-flit packet is in progress
- credit_cnt  out  CW  credits currently available
- credit_err  out  1  sticky; set when credit_in arrives with credit_cnt==CREDITS

## Operation
- State machine has two states.
  - IDLE:
    - When credit_cnt>0 and any req is high, select a winner: a group by the group pointer, then a member by that group's intra-group pointer.
    - Assert grant[winner].
    - If tail[winner]=0, go to LOCKED with owner=winner. Otherwise stay in IDLE.
  - LOCKED:
    - grant[owner]=req[owner] & (credit_cnt>0). No other requester is ever granted.
    - A transfer with tail[owner]=1 returns to IDLE.
    - If req[owner] drops, grant drops and the block stays LOCKED. There is no timeout.
- Round-robin pointers:
  - Group pointer: on a grant in IDLE only, advance to (winning group+1) mod NUMGROUPS.
  - Intra-group pointer of the winning group only: advance to (winner's local index+1) mod GROUPSIZE.
  - Pointers of groups that do not win are unchanged. Grants in LOCKED never move any pointer.
- Credits:
  - grant_valid decrements credit_cnt; credit_in increments it.
  - If both occur in the same cycle, the count is unchanged.
  - If credit_in arrives at CREDITS, the count saturates and credit_err is set. Only rst clears credit_err.
  - No grant is issued when credit_cnt==0, so the count never underflows.
- req and tail bits of non-granted requesters are ignored.

## Timing
- Grant path is combinational: req/tail to grant, zero cycles. Inputs must be stable before the edge.
- State, owner, pointer, and credit updates take effect at the next rising edge.
- A credit returned in cycle t can be used for a grant in cycle t+1.
- Back-to-back packets are allowed:
  - A tail transfer in cycle t makes a new IDLE arbitration possible in cycle t+1.
  - A single-flit packet every cycle is sustained if credits allow.
- Values while rst is asserted and immediately after release:
  - state=IDLE; all pointers 0, so requester 0 and group 0 have highest priority.
  - credit_cnt=CREDITS, locked=0, credit_err=0.
  - grant is forced to 0 while rst is high.
- Asserting rst mid-packet abandons the packet immediately. No tail is required to recover.
- locked mirrors the registered state. It is 1 in the cycle after a non-tail head transfer, through the cycle of the tail transfer.

## Test plan
- Single packet:
  - Stimulus: reset, then req[5]=1 for 3 cycles with tail[5]=0,0,1.
  - Response: grant[5] for 3 cycles; locked=1 in cycles 2-3; credit_cnt goes 4→1; state returns to IDLE.
- Round-robin fairness:
  - Stimulus: req=20'hFFFFF held, all tail=1, credit_in each cycle.
  - Response: grant_idx sequence 0,4,8,12,16,1,5,9,13,17,2,…; every requester is granted once per 20 cycles.
- Packet lock:
  - Stimulus: req[2] starts a 4-flit packet; req[9] rises during flit 2; req[2] drops for one cycle mid-packet.
  - Response: no grant in the drop cycle; locked stays 1; grant[9] only in the cycle after req[2]'s tail.
- Credit exhaustion:
  - Stimulus: CREDITS=4 with continuous single-flit requests and no credit_in.
  - Response: 4 grants, then grant_valid=0.
  - Stimulus: one credit_in pulse.
  - Response: exactly one grant, in the next cycle.
  - Stimulus: credit_in in the same cycle as a grant.
  - Response: credit_cnt unchanged.
- Credit overflow:
  - Stimulus: credit_in with credit_cnt=4.
  - Response: credit_cnt stays 4; credit_err=1 and stays set until rst.
- Reset mid-packet:
  - Stimulus: assert rst between a packet's head and tail flits.
  - Response: grant=0 and locked=0 immediately; credit_cnt=4; the next grant goes to the lowest-index requesting VC.

Source files
------------

// File: rtl/lag_packet_port_scheduler.sv
// Packet-level two-level round-robin scheduler for one router output port.
// Holds the grant from head to tail flit and tracks downstream credits.
module lag_packet_port_scheduler #(
    parameter int unsigned SIZE      = 20,
    parameter int unsigned GROUPSIZE = 4,
    parameter int unsigned NUMGROUPS = SIZE / GROUPSIZE,
    parameter int unsigned CREDITS   = 4,
    parameter int unsigned CW        = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIZE-1:0]         req,
    input  logic [SIZE-1:0]         tail,
    input  logic                    credit_in,
    output logic [SIZE-1:0]         grant,
    output logic                    grant_valid,
    output logic [$clog2(SIZE)-1:0] grant_idx,
    output logic                    locked,
    output logic [CW-1:0]           credit_cnt,
    output logic                    credit_err
);

    localparam int unsigned IW  = $clog2(SIZE);
    localparam int unsigned GPW = (NUMGROUPS > 1) ? $clog2(NUMGROUPS) : 1;
    localparam int unsigned LW  = (GROUPSIZE > 1) ? $clog2(GROUPSIZE) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t            state, state_d;
    logic [IW-1:0]     owner, owner_d;
    logic [GPW-1:0]    grp_ptr, grp_ptr_d;
    logic [LW-1:0]     intra_ptr   [NUMGROUPS];
    logic [LW-1:0]     intra_ptr_d [NUMGROUPS];
    logic [CW-1:0]     credit_cnt_d;
    logic              credit_err_d;

    logic              any_sel;
    logic              found_loc;
    logic [GPW-1:0]    sel_grp;
    logic [LW-1:0]     sel_loc;
    logic [GROUPSIZE-1:0] grp_req;
    logic [IW-1:0]     win;
    logic              has_credit;

    // Winner search: first requesting group from grp_ptr, then first member from its pointer
    always_comb begin
        any_sel   = 1'b0;
        found_loc = 1'b0;
        sel_grp   = '0;
        sel_loc   = '0;
        for (int k = 0; k < int'(NUMGROUPS); k++) begin
            if (!any_sel &&
                (|req[((int'(grp_ptr) + k) % int'(NUMGROUPS)) * int'(GROUPSIZE) +: GROUPSIZE])) begin
                any_sel = 1'b1;
                sel_grp = GPW'((int'(grp_ptr) + k) % int'(NUMGROUPS));
            end
        end
        grp_req = req[int'(sel_grp) * int'(GROUPSIZE) +: GROUPSIZE];
        for (int j = 0; j < int'(GROUPSIZE); j++) begin
            if (!found_loc && grp_req[(int'(intra_ptr[sel_grp]) + j) % int'(GROUPSIZE)]) begin
                found_loc = 1'b1;
                sel_loc   = LW'((int'(intra_ptr[sel_grp]) + j) % int'(GROUPSIZE));
            end
        end
        win = IW'(int'(sel_grp) * int'(GROUPSIZE) + int'(sel_loc));
    end

    assign has_credit = (credit_cnt != '0);

    // Next-state, pointer and grant logic
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        grp_ptr_d   = grp_ptr;
        intra_ptr_d = intra_ptr;
        grant       = '0;
        grant_idx   = '0;
        case (state)
            S_IDLE: begin
                if (!rst && has_credit && any_sel && found_loc) begin
                    grant[win] = 1'b1;
                    grant_idx  = win;
                    grp_ptr_d  = GPW'((int'(sel_grp) + 1) % int'(NUMGROUPS));
                    intra_ptr_d[sel_grp] = LW'((int'(sel_loc) + 1) % int'(GROUPSIZE));
                    if (!tail[win]) begin
                        state_d = S_LOCKED;
                        owner_d = win;
                    end
                end
            end
            S_LOCKED: begin
                if (!rst && has_credit && req[owner]) begin
                    grant[owner] = 1'b1;
                    grant_idx    = owner;
                    if (tail[owner]) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign grant_valid = |grant;
    assign locked      = (state == S_LOCKED);

    // Credit accounting; a simultaneous grant and return cancel out
    always_comb begin
        credit_cnt_d = credit_cnt;
        credit_err_d = credit_err | (credit_in && (credit_cnt == CW'(CREDITS)));
        case ({grant_valid, credit_in})
            2'b10:   credit_cnt_d = credit_cnt - CW'(1);
            2'b01:   credit_cnt_d = (credit_cnt == CW'(CREDITS)) ? credit_cnt : credit_cnt + CW'(1);
            default: credit_cnt_d = credit_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= '0;
            grp_ptr    <= '0;
            intra_ptr  <= '{default: '0};
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            grp_ptr    <= grp_ptr_d;
            intra_ptr  <= intra_ptr_d;
            credit_cnt <= credit_cnt_d;
            credit_err <= credit_err_d;
        end
    end

endmodule
